// File: rtl/iboot_rom_load_sequencer.sv
// Copies a contiguous range of boot-ROM words into the iboot ROM FIFO write port, one read at a time.
// Define IBOOT_ROM_LOAD_SEQUENCER_CHECKSUM_EN to add the oCHECKSUM running sum of written words.
module iboot_rom_load_sequencer #(
   parameter int N   = 32,
   parameter int A_N = 10
) (
   input  logic           iCLOCK,
   input  logic           iRESET_SYNC,
   input  logic           iSTART,
   input  logic           iABORT,
   input  logic [A_N-1:0] iBASE_ADDR,
   input  logic [A_N:0]   iWORD_COUNT,
   output logic           oBUSY,
   output logic           oDONE,
   output logic           oROM_REQ,
   output logic [A_N-1:0] oROM_ADDR,
   input  logic           iROM_VALID,
   input  logic [N-1:0]   iROM_DATA,
   output logic           oFIFO_WR_EN,
   output logic [N-1:0]   oFIFO_WR_DATA,
   input  logic           iFIFO_WR_FULL
`ifdef IBOOT_ROM_LOAD_SEQUENCER_CHECKSUM_EN
   ,
   output logic [N-1:0]   oCHECKSUM
`endif
);

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, PUSH, DONE} state_t;

   state_t         state;
   logic [A_N-1:0] addr;
   logic [A_N:0]   remaining;
   logic [N-1:0]   hold;
   logic           busy_q;
   logic           done_q;
   logic           req_q;
   logic           wr;

   // The write strobe follows full combinationally; abort and reset both veto it in their own cycle.
   assign wr            = (state == PUSH) && !iFIFO_WR_FULL && !iABORT && !iRESET_SYNC;
   assign oFIFO_WR_EN   = wr;
   assign oFIFO_WR_DATA = hold;
   assign oROM_ADDR     = addr;
   assign oBUSY         = busy_q;
   assign oDONE         = done_q;
   assign oROM_REQ      = req_q;

   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         state     <= IDLE;
         addr      <= '0;
         remaining <= '0;
         hold      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         req_q     <= 1'b0;
      end else if (iABORT) begin
         state  <= IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         req_q  <= 1'b0;
      end else begin
         req_q  <= 1'b0;
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (iSTART) begin
                  addr      <= iBASE_ADDR;
                  remaining <= iWORD_COUNT;
                  busy_q    <= 1'b1;
                  if (iWORD_COUNT == '0) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end else begin
                     state <= FETCH;
                     req_q <= 1'b1;
                  end
               end
            end
            FETCH: state <= WAIT;
            WAIT: begin
               if (iROM_VALID) begin
                  hold  <= iROM_DATA;
                  state <= PUSH;
               end
            end
            PUSH: begin
               if (wr) begin
                  addr      <= addr + A_N'(1);
                  remaining <= remaining - (A_N+1)'(1);
                  if (remaining == (A_N+1)'(1)) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end else begin
                     state <= FETCH;
                     req_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef IBOOT_ROM_LOAD_SEQUENCER_CHECKSUM_EN
   logic [N-1:0] csum;

   // Cleared only by an accepted start so the value stays readable after DONE.
   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         csum <= '0;
      end else if ((state == IDLE) && iSTART && !iABORT) begin
         csum <= '0;
      end else if (wr) begin
         csum <= csum + hold;
      end
   end

   assign oCHECKSUM = csum;
`endif

endmodule
